// File: rtl/pfb_pkg.sv
// -----------------------------------------------------------------------------
// pfb_pkg
// Shared constants for the polyphase-filterbank multiply-accumulate cascade.
//   DATA_WIDTH        : sample width, Q1.15
//   COEF_WIDTH        : coefficient width, Q1.24
//   CASCADE_WIDTH     : width of the cascade word passed between tap stages
//   MAX_FFT_LOG2      : log2 of the largest supported phase count
//   CASCADE_FRAC_BITS : fractional bits carried in the cascade word; the tail
//                       rounding stage takes bits [39:24] as its Q1.15 result
//   MIN_FFT_LOG2      : smallest supported phase count log2
// clamp_fft_log2 forces a requested phase-count log2 into the supported range,
// so an out-of-range request never produces a degenerate counter limit.
// -----------------------------------------------------------------------------
package pfb_pkg;

   localparam int DATA_WIDTH        = 16;
   localparam int COEF_WIDTH        = 25;
   localparam int CASCADE_WIDTH     = 48;
   localparam int MAX_FFT_LOG2      = 11;
   localparam int CASCADE_FRAC_BITS = 39;

   localparam logic [3:0] MIN_FFT_LOG2 = 4'd3;

   function automatic logic [3:0] clamp_fft_log2(input logic [3:0] req,
                                                 input logic [3:0] max_log2);
      logic [3:0] res;
      if (req < MIN_FFT_LOG2) begin
         res = MIN_FFT_LOG2;
      end else if (req > max_log2) begin
         res = max_log2;
      end else begin
         res = req;
      end
      return res;
   endfunction

endpackage

// File: rtl/pfb_coef_ram.sv
// -----------------------------------------------------------------------------
// pfb_coef_ram
// Simple dual-port coefficient RAM: one write port, one registered read port,
// read-first on an address collision. Written in the plain inferred block-RAM
// form; contents are deliberately not reset.
// Ports:
//   clk      in  clock
//   wr_en    in  write strobe (independent of any pipeline enable)
//   wr_addr  in  write address
//   wr_data  in  write data
//   rd_en    in  read enable; low holds rd_data
//   rd_addr  in  read address
//   rd_data  out registered read data (one cycle after rd_en)
// -----------------------------------------------------------------------------
module pfb_coef_ram #(
   parameter int ADDR_WIDTH = pfb_pkg::MAX_FFT_LOG2,
   parameter int WORD_WIDTH = pfb_pkg::COEF_WIDTH
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WORD_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WORD_WIDTH-1:0] rd_data
);

   logic [WORD_WIDTH-1:0] mem_r [0:(2**ADDR_WIDTH)-1];

   // Write port: lands in one cycle whenever the strobe is high.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Read port: non-blocking read of the array gives the pre-write word on a
   // same-address collision (read-first).
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem_r[rd_addr];
      end
   end

endmodule

// File: rtl/pfb_mac_head.sv
// -----------------------------------------------------------------------------
// pfb_mac_head
// Head stage of the polyphase-filterbank MAC cascade. Each accepted Q1.15
// sample is tagged with the current phase, multiplied by that phase's Q1.24
// coefficient and emitted as a sign-extended 48-bit cascade word with 39
// fractional bits. Three-stage pipeline, all stages frozen by the shared ce.
// Ports:
//   clk           in  clock
//   reset         in  asynchronous active-high reset
//   ce            in  cascade clock enable; low freezes every register
//   fft_log2      in  requested phase-count log2 (3..MAX_FFT_LOG2)
//   s_tvalid      in  sample valid
//   s_tdata       in  signed sample
//   s_tready      out equals ce
//   coef_wr_en    in  coefficient write strobe (not gated by ce)
//   coef_wr_addr  in  coefficient phase index
//   coef_wr_data  in  signed coefficient
//   pcout         out cascade word (zero on bubbles)
//   pcout_valid   out pcout carries a product
//   pcout_phase   out phase index of pcout
//   pcout_last    out pcout is the final phase of its frame
// -----------------------------------------------------------------------------
module pfb_mac_head #(
   parameter int MAX_FFT_LOG2 = pfb_pkg::MAX_FFT_LOG2,
   parameter int DATA_WIDTH   = pfb_pkg::DATA_WIDTH,
   parameter int COEF_WIDTH   = pfb_pkg::COEF_WIDTH
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               ce,
   input  logic [3:0]                         fft_log2,
   input  logic                               s_tvalid,
   input  logic [DATA_WIDTH-1:0]              s_tdata,
   output logic                               s_tready,
   input  logic                               coef_wr_en,
   input  logic [MAX_FFT_LOG2-1:0]            coef_wr_addr,
   input  logic [COEF_WIDTH-1:0]              coef_wr_data,
   output logic [pfb_pkg::CASCADE_WIDTH-1:0]  pcout,
   output logic                               pcout_valid,
   output logic [MAX_FFT_LOG2-1:0]            pcout_phase,
   output logic                               pcout_last
);

   import pfb_pkg::*;

   localparam int         PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
   localparam int         EXT_WIDTH  = CASCADE_WIDTH - PROD_WIDTH;
   localparam logic [3:0] MAX_LOG2_4 = 4'(MAX_FFT_LOG2);

   localparam logic [MAX_FFT_LOG2-1:0]  PHASE_ZERO = {MAX_FFT_LOG2{1'b0}};
   localparam logic [MAX_FFT_LOG2-1:0]  PHASE_ONE  = {{(MAX_FFT_LOG2-1){1'b0}}, 1'b1};
   localparam logic [MAX_FFT_LOG2-1:0]  PHASE_ONES = {MAX_FFT_LOG2{1'b1}};
   localparam logic [DATA_WIDTH-1:0]    DATA_ZERO  = {DATA_WIDTH{1'b0}};
   localparam logic [COEF_WIDTH-1:0]    COEF_ZERO  = {COEF_WIDTH{1'b0}};
   localparam logic [CASCADE_WIDTH-1:0] CASC_ZERO  = {CASCADE_WIDTH{1'b0}};

   // Phase counter and frame-size control
   logic                    accept_s;
   logic                    wrap_s;
   logic [3:0]              nfft_eff_s;
   logic [3:0]              nfft_act_r;
   logic                    load_pend_r;
   logic [MAX_FFT_LOG2-1:0] limit_s;
   logic [MAX_FFT_LOG2-1:0] phase_cnt_r;

   // Pipeline stage 1
   logic                    s1_valid_r;
   logic                    s1_last_r;
   logic [MAX_FFT_LOG2-1:0] s1_phase_r;
   logic [DATA_WIDTH-1:0]   s1_data_r;

   // Coefficient read data, aligned with stage 1
   logic [COEF_WIDTH-1:0]   ram_q_s;

   // Pipeline stage 2
   logic                    s2_valid_r;
   logic                    s2_last_r;
   logic [MAX_FFT_LOG2-1:0] s2_phase_r;
   logic signed [DATA_WIDTH-1:0] s2_data_r;
   logic signed [COEF_WIDTH-1:0] s2_coef_r;
   logic signed [PROD_WIDTH-1:0] prod_s;

   // Pipeline stage 3 (output registers)
   logic [CASCADE_WIDTH-1:0] pcout_r;
   logic                     pcout_valid_r;
   logic [MAX_FFT_LOG2-1:0]  pcout_phase_r;
   logic                     pcout_last_r;

   assign s_tready    = ce;
   assign pcout       = pcout_r;
   assign pcout_valid = pcout_valid_r;
   assign pcout_phase = pcout_phase_r;
   assign pcout_last  = pcout_last_r;

   // Acceptance, effective frame size and end-of-frame detection.
   always_comb begin
      accept_s = s_tvalid & ce;
      // On the first clock after reset the latched size is not loaded yet, so
      // the live request is used directly for that cycle's limit.
      if (load_pend_r) begin
         nfft_eff_s = clamp_fft_log2(fft_log2, MAX_LOG2_4);
      end else begin
         nfft_eff_s = nfft_act_r;
      end
      limit_s = ~(PHASE_ONES << nfft_eff_s);
      // >= rather than == keeps the counter bounded even if the limit ever
      // drops below it.
      if (phase_cnt_r >= limit_s) begin
         wrap_s = 1'b1;
      end else begin
         wrap_s = 1'b0;
      end
   end

   // Latched frame size: loads after reset release and at every frame wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_pend_r <= 1'b1;
         nfft_act_r  <= MIN_FFT_LOG2;
      end else if (load_pend_r) begin
         load_pend_r <= 1'b0;
         nfft_act_r  <= nfft_eff_s;
      end else if (accept_s && wrap_s) begin
         nfft_act_r  <= clamp_fft_log2(fft_log2, MAX_LOG2_4);
      end
   end

   // Phase counter: advances per accepted sample, wraps at the frame limit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_cnt_r <= PHASE_ZERO;
      end else if (accept_s) begin
         if (wrap_s) begin
            phase_cnt_r <= PHASE_ZERO;
         end else begin
            phase_cnt_r <= phase_cnt_r + PHASE_ONE;
         end
      end
   end

   // Stage 1: capture sample and tags; bubbles carry all-zero payloads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_r <= 1'b0;
         s1_last_r  <= 1'b0;
         s1_phase_r <= PHASE_ZERO;
         s1_data_r  <= DATA_ZERO;
      end else if (ce) begin
         s1_valid_r <= s_tvalid;
         if (s_tvalid) begin
            s1_last_r  <= wrap_s;
            s1_phase_r <= phase_cnt_r;
            s1_data_r  <= s_tdata;
         end else begin
            s1_last_r  <= 1'b0;
            s1_phase_r <= PHASE_ZERO;
            s1_data_r  <= DATA_ZERO;
         end
      end
   end

   // The read is issued at the counter value in the same cycle the sample is
   // captured, so the coefficient arrives alongside stage 1.
   pfb_coef_ram #(
      .ADDR_WIDTH (MAX_FFT_LOG2),
      .WORD_WIDTH (COEF_WIDTH)
   ) u_coef_ram (
      .clk     (clk),
      .wr_en   (coef_wr_en),
      .wr_addr (coef_wr_addr),
      .wr_data (coef_wr_data),
      .rd_en   (ce),
      .rd_addr (phase_cnt_r),
      .rd_data (ram_q_s)
   );

   // Stage 2: align the registered coefficient with the sample and tags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid_r <= 1'b0;
         s2_last_r  <= 1'b0;
         s2_phase_r <= PHASE_ZERO;
         s2_data_r  <= DATA_ZERO;
         s2_coef_r  <= COEF_ZERO;
      end else if (ce) begin
         s2_valid_r <= s1_valid_r;
         s2_last_r  <= s1_last_r;
         s2_phase_r <= s1_phase_r;
         s2_data_r  <= s1_data_r;
         s2_coef_r  <= ram_q_s;
      end
   end

   // Full-precision signed product; -1.0 x -1.0 = +2^39 still fits in 41 bits.
   always_comb begin
      prod_s = s2_data_r * s2_coef_r;
   end

   // Stage 3: sign-extend into the cascade word; bubbles contribute zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcout_r       <= CASC_ZERO;
         pcout_valid_r <= 1'b0;
         pcout_phase_r <= PHASE_ZERO;
         pcout_last_r  <= 1'b0;
      end else if (ce) begin
         pcout_valid_r <= s2_valid_r;
         if (s2_valid_r) begin
            pcout_r       <= {{EXT_WIDTH{prod_s[PROD_WIDTH-1]}}, prod_s};
            pcout_phase_r <= s2_phase_r;
            pcout_last_r  <= s2_last_r;
         end else begin
            pcout_r       <= CASC_ZERO;
            pcout_phase_r <= PHASE_ZERO;
            pcout_last_r  <= 1'b0;
         end
      end
   end

endmodule
